// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Drives a sync-read imem; handles stall, redirect and hlt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic              id_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] tgt;
  logic        is_hlt;
  if_id_t      ifid;
  if_id_t      ifid_nx;

  assign tgt    = redirect_pc & ~32'h3;
  assign is_hlt = imem_rdata[6:0] == 7'h7f;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ifid_nx  = ifid;
    unique case (state)
      BOOT: begin
        pc_nx         = RESET_PC;
        ifid_nx.instr = NOP_INSTR;
        ifid_nx.valid = 1'b0;
        state_nx      = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_nx         = tgt;
          ifid_nx.instr = NOP_INSTR;
          ifid_nx.valid = 1'b0;
        end else if (!stall) begin
          pc_nx         = pc + 32'd4;
          ifid_nx.instr = imem_rdata;
          ifid_nx.pc    = pc;
          ifid_nx.valid = 1'b1;
          if (is_hlt) state_nx = HALT;
        end
      end
      HALT: begin
        // a redirect means the hlt was on the wrong path
        if (redirect) begin
          pc_nx         = tgt;
          ifid_nx.instr = NOP_INSTR;
          ifid_nx.valid = 1'b0;
          state_nx      = RUN;
        end else if (!stall) begin
          ifid_nx.instr = NOP_INSTR;
          ifid_nx.valid = 1'b0;
        end
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  assign imem_addr = pc_nx[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid.instr <= NOP_INSTR;
      ifid.pc    <= RESET_PC;
      ifid.valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      ifid   <= ifid_nx;
      halted <= state_nx == HALT;
    end
  end

  assign id_instr = ifid.instr;
  assign id_pc    = ifid.pc;
  assign id_valid = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed boot/stall/redirect/halt
// sequence, then random stall/redirect against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST = 32'h0000_0040;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          id_valid;
  logic          halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];

  fetch_stage #(
    .RESET_PC (RST),
    .ADDR_W   (AW),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // reference model: fa = byte address of the next word to deliver
  bit          m_boot;
  bit          m_halt;
  logic [31:0] m_fa;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  bit          e_valid;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_boot  = 1;
    m_halt  = 0;
    m_fa    = RST;
    e_instr = NOP;
    e_pc    = RST;
    e_valid = 0;
  endfunction

  function automatic logic [31:0] m_addr();
    logic [31:0] a;
    if (m_boot) a = RST;
    else if (redirect) a = redirect_pc;
    else if (stall || m_halt) a = m_fa;
    else a = m_fa + 32'd4;
    return {22'b0, a[11:2]};
  endfunction

  function automatic void m_edge();
    logic [31:0] w;
    if (m_boot) begin
      m_boot  = 0;
      m_fa    = RST;
      e_instr = NOP;
      e_valid = 0;
    end else if (redirect) begin
      m_fa    = redirect_pc & ~32'h3;
      m_halt  = 0;
      e_instr = NOP;
      e_valid = 0;
    end else if (stall) begin
    end else if (m_halt) begin
      e_instr = NOP;
      e_valid = 0;
    end else begin
      w       = mem[m_fa[11:2]];
      e_instr = w;
      e_pc    = m_fa;
      e_valid = 1;
      if (w[6:0] == 7'h7f) m_halt = 1;
      m_fa    = m_fa + 32'd4;
    end
  endfunction

  task automatic cyc(input bit s, input bit r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
    check("imem_addr", 32'(imem_addr), m_addr());
    @(posedge clk);
    m_edge();
    #1;
    check("id_valid", 32'(id_valid), 32'(e_valid));
    check("id_instr", id_instr, e_instr);
    check("halted", 32'(halted), 32'(m_halt));
    if (e_valid) check("id_pc", id_pc, e_pc);
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", id_pc, RST);
    check("rst_instr", id_instr, NOP);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if (w[6:0] == 7'h7f) w[0] = 1'b0;
      mem[i] = w;
    end
    mem[16] = 32'h1111_1113;
    mem[17] = 32'h2222_2223;
    mem[18] = 32'h3333_3333;
    mem[20] = 32'hffff_ffff;
    m_reset();

    #22 rst_n = 1'b1;
    check("boot_valid", 32'(id_valid), 32'd0);
    check("boot_pc", id_pc, RST);

    // boot then A, B
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("A", id_instr, 32'h1111_1113);
    check("A_pc", id_pc, 32'h40);
    cyc(0, 0, 0);
    check("B_pc", id_pc, 32'h44);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      check("stall_addr", 32'(imem_addr), 32'h12);
      check("stall_pc", id_pc, 32'h44);
    end
    cyc(0, 0, 0);
    check("C", id_instr, 32'h3333_3333);
    check("C_pc", id_pc, 32'h48);

    cyc(0, 1, 32'h103);
    check("rd_bubble", id_instr, NOP);
    check("rd_valid", 32'(id_valid), 32'd0);
    cyc(0, 0, 0);
    check("rd_pc", id_pc, 32'h100);

    cyc(1, 1, 32'h80);
    check("rs_valid", 32'(id_valid), 32'd0);
    cyc(0, 0, 0);
    check("rs_pc", id_pc, 32'h80);

    cyc(0, 1, 32'h50);
    cyc(0, 0, 0);
    check("hlt_instr", id_instr, 32'hffff_ffff);
    check("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 32'h20);
    check("unhalt", 32'(halted), 32'd0);
    cyc(0, 0, 0);
    check("unhalt_pc", id_pc, 32'h20);
    cyc(0, 0, 0);

    async_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("reboot_pc", id_pc, 32'h40);

    for (int k = 0; k < 24; k++) begin
      w = $urandom;
      w[6:0] = 7'h7f;
      mem[$urandom_range(0, 1023)] = w;
    end
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
